// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and register-index width for the hazard controller
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {RUN = 2'd0, MWAIT = 2'd1, FAULT = 2'd2} state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous-clear up-counter that holds at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = clear ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for load-use, taken-branch and data-memory wait hazards
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_RFwe,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_dm_req,
  input  logic             mem_dm_ack,
  output logic             pc_stop,
  output logic             ifid_stop,
  output logic             ifid_flush,
  output logic             idex_stop,
  output logic             idex_flush,
  output logic             exmem_stop,
  output logic             memwb_flush,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_e      state_d, state_q;
  logic [15:0] wait_cnt_d, wait_cnt_q;
  logic        lu_haz, mw, freeze, br_evt;
  assign lu_haz = ex_is_load && ex_RFwe && ex_rd != '0 &&
                  ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  assign mw = mem_dm_req && !mem_dm_ack;
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    freeze      = 1'b0;
    br_evt      = 1'b0;
    pc_stop     = 1'b0;
    ifid_stop   = 1'b0;
    ifid_flush  = 1'b0;
    idex_stop   = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    fault       = 1'b0;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == FAULT) begin
      freeze = 1'b1;
      fault  = 1'b1;
    end else if (mw) begin
      freeze = 1'b1;
      if (state_q == RUN) begin
        state_d    = MWAIT;
        wait_cnt_d = 16'd1;
      end else if (wait_cnt_q == 16'(MEM_TIMEOUT)) begin
        state_d = FAULT;
        fault   = 1'b1;
      end else wait_cnt_d = wait_cnt_q + 16'd1;
    end else begin
      // release cycle of a wait decodes exactly like RUN
      state_d    = RUN;
      wait_cnt_d = '0;
      br_evt     = ex_br_taken;
      pc_stop    = !ex_br_taken && lu_haz;
      ifid_stop  = !ex_br_taken && lu_haz;
      ifid_flush = ex_br_taken;
      idex_flush = ex_br_taken || lu_haz;
    end
    if (freeze) begin
      pc_stop     = 1'b1;
      ifid_stop   = 1'b1;
      idex_stop   = 1'b1;
      memwb_flush = 1'b1;
    end
  end
  assign exmem_stop = freeze;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .clear(!rst_n), .inc(pc_stop), .cnt(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .clear(!rst_n), .inc(br_evt), .cnt(flush_cnt));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with hand-computed responses for the hazard controller
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_RFwe, ex_is_load, ex_br_taken, mem_dm_req, mem_dm_ack;
  logic       pc_stop, ifid_stop, ifid_flush, idex_stop, idex_flush, exmem_stop, memwb_flush, fault;
  logic [3:0] stall_cnt, flush_cnt;
  logic [7:0] outs;
  int         n_chk = 0, n_fail = 0;
  localparam logic [7:0] O_IDLE = 8'h00, O_RST = 8'h2A, O_LU = 8'hC8, O_BR = 8'h28,
                         O_FRZ = 8'hD6, O_FLT = 8'hD7;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_RFwe(ex_RFwe), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .mem_dm_req(mem_dm_req), .mem_dm_ack(mem_dm_ack),
    .pc_stop(pc_stop), .ifid_stop(ifid_stop), .ifid_flush(ifid_flush), .idex_stop(idex_stop),
    .idex_flush(idex_flush), .exmem_stop(exmem_stop), .memwb_flush(memwb_flush), .fault(fault),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  assign outs = {pc_stop, ifid_stop, ifid_flush, idex_stop, idex_flush, exmem_stop, memwb_flush, fault};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_RFwe, ex_is_load, ex_br_taken, mem_dm_req, mem_dm_ack} = '0;
  endtask
  task automatic lu_in();
    idle_in();
    ex_is_load = 1'b1; ex_RFwe = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
  endtask
  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    idle_in();
    rst_n = 1'b0;
    #1 chk("reset_outs", outs, O_RST);
    step();
    chk("reset_stall", stall_cnt, 0);
    chk("reset_flush", flush_cnt, 0);
    rst_n = 1'b1;
    #1 chk("idle_outs", outs, O_IDLE);
    lu_in();
    #1 chk("lu_outs", outs, O_LU);
    step();
    idle_in();
    #1 chk("lu_one_cycle", outs, O_IDLE);
    chk("lu_stall_cnt", stall_cnt, 1);
    lu_in(); ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1 chk("x0_outs", outs, O_IDLE);
    lu_in(); id_rs2_used = 1'b0;
    #1 chk("rs2_unused_outs", outs, O_IDLE);
    lu_in(); ex_RFwe = 1'b0;
    #1 chk("no_we_outs", outs, O_IDLE);
    lu_in(); id_rs2_used = 1'b0; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1 chk("lu_rs1_outs", outs, O_LU);
    lu_in(); ex_br_taken = 1'b1;
    #1 chk("br_lu_outs", outs, O_BR);
    step();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 1);
    do_reset();
    #1 chk("rst2_stall", stall_cnt, 0);
    mem_dm_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mwait_outs%0d", i), outs, O_FRZ);
      step();
    end
    mem_dm_ack = 1'b1; ex_br_taken = 1'b1;
    #1 chk("release_br_outs", outs, O_BR);
    step();
    chk("mem_stall_cnt", stall_cnt, 3);
    chk("release_flush_cnt", flush_cnt, 1);
    idle_in();
    #1 chk("after_release_outs", outs, O_IDLE);
    mem_dm_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1 chk($sformatf("to_wait%0d", i), outs, O_FRZ);
      step();
    end
    #1 chk("to_fault5", outs, O_FLT);
    step();
    chk("to_stall_cnt", stall_cnt, 8);
    idle_in();
    #1 chk("fault_sticky", outs, O_FLT);
    step();
    chk("fault_stall_cnt", stall_cnt, 9);
    rst_n = 1'b0;
    #1 chk("fault_rst_outs", outs, O_RST);
    step();
    rst_n = 1'b1;
    #1 chk("post_fault_outs", outs, O_IDLE);
    chk("post_fault_stall", stall_cnt, 0);
    chk("post_fault_flush", flush_cnt, 0);
    lu_in();
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt", stall_cnt, 15);
    chk("sat_outs", outs, O_LU);
    idle_in(); ex_br_taken = 1'b1;
    for (int i = 0; i < 18; i++) step();
    chk("sat_flush_cnt", flush_cnt, 15);
    idle_in();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
